// File: rtl/hms_pkg.sv
// Shared types, limits and BCD helpers for the hh:mm:ss time-of-day counter.
package hms_pkg;

   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned PAIR_W  = 2 * DIGIT_W;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef struct packed {
      digit_t tens;
      digit_t units;
   } pair_t;

   typedef struct packed {
      pair_t hh;
      pair_t mm;
      pair_t ss;
   } hms_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CHECK = 1'b1
   } state_t;

   localparam pair_t SEC_MAX = 8'h59;
   localparam pair_t MIN_MAX = 8'h59;
   localparam pair_t HR_MAX  = 8'h23;

   localparam digit_t DIGIT_MAX = 4'd9;

   // Next value of a two-digit BCD counter that wraps to 00 after max.
   function automatic pair_t bcd_next(input pair_t v, input pair_t max);
      pair_t r;
      if (v == max) begin
         r = '0;
      end else if (v.units == DIGIT_MAX) begin
         r.tens  = v.tens + DIGIT_W'(1);
         r.units = '0;
      end else begin
         r.tens  = v.tens;
         r.units = v.units + DIGIT_W'(1);
      end
      return r;
   endfunction

   // Both nibbles are decimal digits and the pair does not exceed max.
   // Packed BCD orders like binary once each nibble is known to be <= 9.
   function automatic logic bcd_in_range(input pair_t v, input pair_t max);
      return (v.tens <= DIGIT_MAX) && (v.units <= DIGIT_MAX) &&
             (PAIR_W'(v) <= PAIR_W'(max));
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter wrapping at MAX, with synchronous load.
module bcd_mod_counter
   import hms_pkg::*;
#(
   parameter pair_t MAX = SEC_MAX
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  inc,
   input  logic  load,
   input  pair_t load_val,
   output pair_t val,
   output logic  carry_c
);

   // Carry is combinational so a whole cascade rolls over on one edge.
   always_comb begin
      carry_c = inc && !load && (val == MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val <= '0;
      end else if (load) begin
         val <= load_val;
      end else if (inc) begin
         val <= bcd_next(val, MAX);
      end
   end

endmodule

// File: rtl/hms_time_counter.sv
// 24-hour BCD time-of-day: 1 Hz prescaler, cascaded ss/mm/hh counters and a
// validated load handshake (IDLE accepts, CHECK validates for one cycle).
module hms_time_counter
   import hms_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 1000,
   parameter int unsigned PRESCALE_W = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load_valid,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   input  logic [7:0] load_ss,
   output logic       load_ready,
   output logic       load_err,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       sec_tick
);

   localparam int unsigned TERM_I = CLK_HZ - 1;
   localparam logic [PRESCALE_W-1:0] TERM = PRESCALE_W'(TERM_I);

   state_t                state;
   logic [PRESCALE_W-1:0] pres;
   hms_t                  lat;

   logic  accept_c;
   logic  tick_c;
   logic  inc_c;
   logic  load_ok_c;
   logic  apply_c;
   logic  ss_carry_c;
   logic  mm_carry_c;
   logic  hh_carry_c;
   pair_t ss_val;
   pair_t mm_val;
   pair_t hh_val;

   // An accepted load discards a coincident tick.
   always_comb begin
      accept_c  = (state == IDLE) && load_valid && load_ready;
      tick_c    = (state == IDLE) && en && (pres == TERM);
      inc_c     = tick_c && !accept_c;
      load_ok_c = bcd_in_range(lat.hh, HR_MAX) &&
                  bcd_in_range(lat.mm, MIN_MAX) &&
                  bcd_in_range(lat.ss, SEC_MAX);
      apply_c   = (state == CHECK) && load_ok_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pres       <= '0;
         lat        <= '0;
         load_ready <= 1'b1;
         load_err   <= 1'b0;
         sec_tick   <= 1'b0;
      end else begin
         load_err <= 1'b0;
         sec_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  pres <= tick_c ? '0 : pres + PRESCALE_W'(1);
               end
               sec_tick <= inc_c;
               if (accept_c) begin
                  lat.hh     <= pair_t'(load_hh);
                  lat.mm     <= pair_t'(load_mm);
                  lat.ss     <= pair_t'(load_ss);
                  state      <= CHECK;
                  load_ready <= 1'b0;
               end
            end
            CHECK: begin
               // Valid load restarts the second; a rejected one keeps the phase.
               state      <= IDLE;
               load_ready <= 1'b1;
               if (load_ok_c) begin
                  pres <= '0;
               end else begin
                  load_err <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

   bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_c),
      .load     (apply_c),
      .load_val (lat.ss),
      .val      (ss_val),
      .carry_c  (ss_carry_c)
   );

   bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (ss_carry_c),
      .load     (apply_c),
      .load_val (lat.mm),
      .val      (mm_val),
      .carry_c  (mm_carry_c)
   );

   // Hour carry marks the midnight rollover; nothing downstream needs it.
   bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (mm_carry_c),
      .load     (apply_c),
      .load_val (lat.hh),
      .val      (hh_val),
      .carry_c  (hh_carry_c)
   );

   always_comb begin
      hh = hh_val;
      mm = mm_val;
      ss = ss_val;
   end

   logic unused_c;
   assign unused_c = hh_carry_c;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: seconds-of-day reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_hms_time_counter;

   localparam int CLK_HZ = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_hh = 8'h00;
   logic [7:0] load_mm = 8'h00;
   logic [7:0] load_ss = 8'h00;
   logic       load_ready;
   logic       load_err;
   logic [7:0] hh;
   logic [7:0] mm;
   logic [7:0] ss;
   logic       sec_tick;

   int n_checks = 0;
   int n_fail   = 0;

   hms_time_counter #(.CLK_HZ(CLK_HZ), .PRESCALE_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .load_valid (load_valid),
      .load_hh    (load_hh),
      .load_mm    (load_mm),
      .load_ss    (load_ss),
      .load_ready (load_ready),
      .load_err   (load_err),
      .hh         (hh),
      .mm         (mm),
      .ss         (ss),
      .sec_tick   (sec_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: time as seconds since midnight ----------------
   int m_tod   = 0;
   int m_phase = 0;
   bit m_busy  = 0;
   bit m_ok    = 0;
   int m_lt    = 0;
   bit e_tick  = 0;
   bit e_err   = 0;
   bit e_ready = 1;
   int vh, vm, vs;
   bit tick;

   function automatic int bcd_val(input logic [7:0] b);
      if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tod = 0; m_phase = 0; m_busy = 0; m_ok = 0;
         e_tick = 0; e_err = 0; e_ready = 1;
      end else begin
         e_tick = 0;
         e_err  = 0;
         if (m_busy) begin
            if (m_ok) begin
               m_tod   = m_lt;
               m_phase = 0;
            end else begin
               e_err = 1;
            end
            m_busy = 0;
         end else begin
            tick = 0;
            if (en) begin
               if (m_phase == CLK_HZ - 1) begin
                  m_phase = 0;
                  tick = 1;
               end else begin
                  m_phase++;
               end
            end
            if (load_valid) begin
               vh = bcd_val(load_hh);
               vm = bcd_val(load_mm);
               vs = bcd_val(load_ss);
               m_ok = (vh >= 0 && vh <= 23 && vm >= 0 && vm <= 59 && vs >= 0 && vs <= 59);
               m_lt = vh * 3600 + vm * 60 + vs;
               m_busy = 1;
            end else if (tick) begin
               m_tod  = (m_tod + 1) % 86400;
               e_tick = 1;
            end
         end
         e_ready = !m_busy;
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      check("hh",         32'(hh),         32'(to_bcd(m_tod / 3600)));
      check("mm",         32'(mm),         32'(to_bcd((m_tod / 60) % 60)));
      check("ss",         32'(ss),         32'(to_bcd(m_tod % 60)));
      check("sec_tick",   32'(sec_tick),   32'(e_tick));
      check("load_err",   32'(load_err),   32'(e_err));
      check("load_ready", 32'(load_ready), 32'(e_ready));
   end

   // ---------------- stimulus helpers ----------------
   // Present a load at a negedge once ready is seen; returns at the negedge after acceptance.
   task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      int i;
      for (i = 0; i < 10 && !load_ready; i++) @(negedge clk);
      check("load_ready_wait", 32'(load_ready), 32'd1);
      load_hh = h; load_mm = m; load_ss = s;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic check_time(input string name, input logic [7:0] h, input logic [7:0] m,
                             input logic [7:0] s);
      check({name, "_hh"}, 32'(hh), 32'(h));
      check({name, "_mm"}, 32'(mm), 32'(m));
      check({name, "_ss"}, 32'(ss), 32'(s));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      // Reset state
      @(negedge clk);
      check_time("reset", 8'h00, 8'h00, 8'h00);
      check("reset_ready", 32'(load_ready), 32'd1);
      check("reset_err",   32'(load_err),   32'd0);
      check("reset_tick",  32'(sec_tick),   32'd0);
      rst_n = 1'b1;
      en    = 1'b1;

      // 12 enabled cycles: ticks after cycles 4, 8, 12
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         check($sformatf("tick_cyc%0d", c), 32'(sec_tick), 32'((c % 4) == 0));
      end
      check_time("run12", 8'h00, 8'h00, 8'h03);

      // Midnight rollover
      do_load(8'h23, 8'h59, 8'h58);
      check("accept_ready_low", 32'(load_ready), 32'd0);
      @(negedge clk);
      check_time("loaded", 8'h23, 8'h59, 8'h58);
      check("loaded_ready", 32'(load_ready), 32'd1);
      check("loaded_no_tick", 32'(sec_tick), 32'd0);
      repeat (4) @(negedge clk);
      check_time("to_2359_59", 8'h23, 8'h59, 8'h59);
      check("tick_59", 32'(sec_tick), 32'd1);
      repeat (4) @(negedge clk);
      check_time("rollover", 8'h00, 8'h00, 8'h00);
      check("tick_roll", 32'(sec_tick), 32'd1);

      // Out-of-range hour: rejected, one-cycle busy, one-cycle error
      do_load(8'h24, 8'h00, 8'h00);
      check("bad_hr_busy", 32'(load_ready), 32'd0);
      @(negedge clk);
      check("bad_hr_err", 32'(load_err), 32'd1);
      check("bad_hr_ready", 32'(load_ready), 32'd1);
      check_time("bad_hr_keep", 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      check("bad_hr_err_clr", 32'(load_err), 32'd0);

      // Bad minute nibble; prescaler phase carries through (model-checked)
      do_load(8'h01, 8'h5A, 8'h00);
      @(negedge clk);
      check("bad_nib_err", 32'(load_err), 32'd1);
      repeat (6) @(negedge clk);

      // Load accepted on the prescaler's terminal cycle: tick discarded
      for (i = 0; i < 10 && !(m_phase == CLK_HZ - 1 && !m_busy); i++) @(negedge clk);
      check("phase_align", 32'(m_phase), 32'(CLK_HZ - 1));
      load_hh = 8'h12; load_mm = 8'h34; load_ss = 8'h56;
      load_valid = 1'b1;
      @(negedge clk);
      load_valid = 1'b0;
      check("coinc_no_tick", 32'(sec_tick), 32'd0);
      @(negedge clk);
      check_time("coinc", 8'h12, 8'h34, 8'h56);
      check("coinc_no_tick2", 32'(sec_tick), 32'd0);
      for (i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (sec_tick) break;
      end
      check("coinc_next_tick_dist", 32'(i), 32'd4);
      check_time("coinc_after", 8'h12, 8'h34, 8'h57);

      // Load applies with en=0, time then holds
      en = 1'b0;
      do_load(8'h07, 8'h08, 8'h09);
      @(negedge clk);
      repeat (6) @(negedge clk);
      check_time("en0_load", 8'h07, 8'h08, 8'h09);
      en = 1'b1;

      // Asynchronous reset in the middle of CHECK
      do_load(8'h11, 8'h22, 8'h33);
      #2 rst_n = 1'b0;
      #1;
      check_time("async_rst", 8'h00, 8'h00, 8'h00);
      check("async_rst_ready", 32'(load_ready), 32'd1);
      check("async_rst_err",   32'(load_err),   32'd0);
      check("async_rst_tick",  32'(sec_tick),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_time("post_rst", 8'h00, 8'h00, 8'h00);
      check("post_rst_ready", 32'(load_ready), 32'd1);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         en = ($urandom_range(0, 3) != 0);
         load_valid = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 1) == 0) begin
            load_hh = to_bcd(int'($urandom_range(0, 23)));
            load_mm = to_bcd(int'($urandom_range(0, 59)));
            load_ss = to_bcd(int'($urandom_range(55, 59)));
         end else begin
            load_hh = 8'($urandom);
            load_mm = 8'($urandom);
            load_ss = 8'($urandom);
         end
         @(negedge clk);
      end
      load_valid = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
